// File: rtl/hazard_controller.sv
// Hazard and stall controller for the 5-stage core: operand forwarding, load-use and
// control-hazard handling, data-memory wait freeze, and debug event counters.
module hazard_controller #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              freeze;
    logic              load_use;
    logic              branch_flush;
    logic [WAIT_W-1:0] wait_cnt;

    // M-stage result is younger than W-stage, so it takes priority; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && rd_m != 5'd0 && rd_m == src)      return 2'b01;
        else if (we_w && rd_w != 5'd0 && rd_w == src) return 2'b10;
        else                                           return 2'b00;
    endfunction

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        freeze     = 1'b0;
        unique case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    freeze     = 1'b1;
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) state_next = RUN;
                else           freeze     = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    // Hazards held in E during a freeze act in the first cycle the memory is ready.
    always_comb begin
        load_use     = 1'b0;
        branch_flush = 1'b0;
        if (!freeze) begin
            load_use     = ResultSrcE && RD_E != 5'd0 && (RD_E == Rs1_D || RD_E == Rs2_D);
            branch_flush = PCSrcE;
        end
    end

    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        if (rst) begin
            ForwardA_E = fwd_sel(Rs1_E, RD_M, RegWriteM, RD_W, RegWriteW);
            ForwardB_E = fwd_sel(Rs2_E, RD_M, RegWriteM, RD_W, RegWriteW);
            // A taken branch discards the decode instruction, so a load-use stall is moot.
            StallF     = freeze || (load_use && !branch_flush);
            StallD     = freeze || (load_use && !branch_flush);
            StallE     = freeze;
            StallM     = freeze;
            FlushD     = branch_flush;
            FlushE     = branch_flush || load_use;
            FlushW     = freeze;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state <= state_next;
            if (freeze) begin
                if (wait_cnt != WAIT_MAX)  wait_cnt    <= wait_cnt + WAIT_W'(1);
                if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and stall controller for the 5-stage core. It sequences the execute stage and its neighbours.
- Generates the ForwardA_E/ForwardB_E selects consumed by execute_cycle.
- Detects load-use hazards and taken-branch/jump control hazards.
- Freezes the pipe while the data-memory port reports not-ready.
- Keeps saturating stall/flush event counters and a sticky memory-timeout flag for debug.

Parameters:
- CNT_W, 16: width of the stall and flush event counters.
- TIMEOUT, 64: number of consecutive MEM_WAIT cycles after which mem_timeout sets.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-low reset
- Rs1_D, Rs2_D  input  5  source registers of the instruction in decode
- Rs1_E, Rs2_E  input  5  source registers of the instruction in execute
- RD_E, RD_M, RD_W  input  5  destination registers in execute/memory/writeback
- ResultSrcE  input  1  instruction in execute is a load
- RegWriteM, RegWriteW  input  1  register-write enables in memory/writeback
- PCSrcE  input  1  taken branch or jump resolved in execute
- MemReqM  input  1  memory-stage instruction accesses data memory
- MemReadyM  input  1  data memory completes the access this cycle
- ForwardA_E, ForwardB_E  output  2  forwarding selects: 00 register file, 01 ALU_ResultM, 10 ResultW
- StallF, StallD, StallE, StallM  output  1  hold the fetch PC / IF-ID / ID-EX / EX-MEM registers
- FlushD, FlushE, FlushW  output  1  bubble the IF-ID / ID-EX / MEM-WB registers
- mem_timeout  output  1  sticky: a memory wait reached TIMEOUT
- stall_cnt  output  CNT_W  cycles with StallF=1
- flush_cnt  output  CNT_W  cycles with a branch-induced FlushD

Behaviour:
Reset:
- While rst=0, all outputs are 0 and state=RUN.
- Reset asserted mid-wait aborts the wait with no residual stall.

Forwarding (combinational), for src in {Rs1_E→ForwardA_E, Rs2_E→ForwardB_E}:
- 01 if RegWriteM and RD_M!=0 and RD_M==src.
- Else 10 if RegWriteW and RD_W!=0 and RD_W==src.
- Else 00. The M-stage match wins when both stages match.
- x0 is never forwarded.

Load-use (combinational, RUN only):
- lu = ResultSrcE and RD_E!=0 and (RD_E==Rs1_D or RD_E==Rs2_D).
- lu drives StallF=StallD=1 and FlushE=1 for the cycle. This is self-clearing: the next cycle E holds a bubble.

Control hazard (RUN only):
- PCSrcE drives FlushD=FlushE=1.
- When lu and PCSrcE are both high, the flush wins and StallF/StallD stay 0.

FSM states: RUN, MEM_WAIT.
- RUN → MEM_WAIT when MemReqM and !MemReadyM.
- MEM_WAIT → RUN on MemReadyM.
- The freeze is combinational on entry: in any cycle with MemReqM and !MemReadyM, StallF=StallD=StallE=StallM=1 and FlushW=1.
- Load-use and branch outputs are suppressed during the freeze.
- The held E-stage PCSrcE/lu take effect in the first cycle MemReadyM=1.
- MemReqM and MemReadyM both high in RUN means a zero-wait access: no stall, and the state stays RUN.
- StallE and StallM are 1 only during the memory freeze.

Wait counter:
- Internal counter counts MEM_WAIT cycles and clears on entry to RUN.
- When it reaches TIMEOUT, mem_timeout sets on that clock and stays set until reset.
- The FSM keeps waiting; there is no abort.

Event counters (registered, saturating at all-ones, no wrap):
- stall_cnt increments each clock where StallF=1.
- flush_cnt increments each clock where PCSrcE caused FlushD=1.

Test Plan:
- rst low → every output 0. Release, then drive a freeze with rst pulsed low mid-wait → state RUN, all stalls 0 next cycle.
- Rs1_E=5, RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1 → ForwardA_E=01. Then RegWriteM=0 → 10. With RD_M=RD_W=0 → 00.
- ResultSrcE=1, RD_E=7, Rs2_D=7 → StallF=StallD=FlushE=1 for exactly one cycle, and stall_cnt increments by 1.
- PCSrcE=1 with lu also true → FlushD=FlushE=1, StallF=0, and flush_cnt increments by 1.
- MemReqM=1, MemReadyM low for 3 cycles → StallF..StallM=1 and FlushW=1 for 3 cycles, then RUN, and stall_cnt += 3.
- TIMEOUT=4 with MemReadyM held low for 6 cycles → mem_timeout rises on the 4th wait clock and stays 1 after MemReadyM.
